// File: rtl/generador_tiempo_muerto_if.sv
// Signal bundle of the dead-time generator: PWM input, mode select, gate drives
// and swallowed-pulse counter. The DUT uses the slave view, the driver the master view.
interface generador_tiempo_muerto_if;
  logic       In_signal_conmutacion;
  logic       select_salida;
  logic       BUCK_Gate;
  logic       Full_Bridge_A;
  logic       Full_Bridge_B;
  logic [7:0] pulsos_descartados;

  modport master (
    output In_signal_conmutacion,
    output select_salida,
    input  BUCK_Gate,
    input  Full_Bridge_A,
    input  Full_Bridge_B,
    input  pulsos_descartados
  );

  modport slave (
    input  In_signal_conmutacion,
    input  select_salida,
    output BUCK_Gate,
    output Full_Bridge_A,
    output Full_Bridge_B,
    output pulsos_descartados
  );
endinterface

// File: rtl/generador_tiempo_muerto.sv
// Dead-time generator for a buck stage or a full bridge driven from one asynchronous PWM.
// Optional swallowed-pulse counter is built only when PULSE_DROP_COUNT_EN is defined.
module generador_tiempo_muerto #(
  parameter int unsigned DEAD_CYCLES = 50
) (
  input  logic                    CLK_100MHz,
  input  logic                    reset,
  generador_tiempo_muerto_if.slave bus
);

  typedef enum logic [2:0] {
    SAFE  = 3'd0,
    BUCK  = 3'd1,
    FB_A  = 3'd2,
    DT_AB = 3'd3,
    FB_B  = 3'd4,
    DT_BA = 3'd5
  } state_t;

  localparam logic [7:0] LP_DEAD = 8'(DEAD_CYCLES);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sel;
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       w_expired;
  logic       w_swallow;
  logic       r_buck;
  logic       r_fb_a;
  logic       r_fb_b;

  // The entry edge counts as the first of the DEAD_CYCLES off cycles, so expiry is at 1.
  assign w_expired = (r_cnt <= 8'd1);

  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sel   <= bus.select_salida;
      r_state <= SAFE;
      r_cnt   <= LP_DEAD;
      r_buck  <= 1'b0;
      r_fb_a  <= 1'b0;
      r_fb_b  <= 1'b0;
    end else begin
      r_sync1 <= bus.In_signal_conmutacion;
      r_sync2 <= r_sync1;
      r_sel   <= bus.select_salida;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_buck  <= (w_state_next == BUCK) && r_sync2;
      r_fb_a  <= (w_state_next == FB_A);
      r_fb_b  <= (w_state_next == FB_B);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_swallow    = 1'b0;
    if (bus.select_salida != r_sel) begin
      w_state_next = SAFE;
      w_cnt_next   = LP_DEAD;
    end else begin
      case (r_state)
        SAFE: begin
          if (w_expired) begin
            if (!r_sel)
              w_state_next = BUCK;
            else
              w_state_next = r_sync2 ? FB_A : FB_B;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
        BUCK: begin
          w_state_next = BUCK;
        end
        FB_A: begin
          if (!r_sync2) begin
            w_state_next = DT_AB;
            w_cnt_next   = LP_DEAD;
          end
        end
        FB_B: begin
          if (r_sync2) begin
            w_state_next = DT_BA;
            w_cnt_next   = LP_DEAD;
          end
        end
        // Landing back on the leg that was on before means the pulse was swallowed.
        DT_AB: begin
          if (w_expired) begin
            w_state_next = r_sync2 ? FB_A : FB_B;
            w_swallow    = r_sync2;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
        DT_BA: begin
          if (w_expired) begin
            w_state_next = r_sync2 ? FB_A : FB_B;
            w_swallow    = !r_sync2;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
        default: begin
          w_state_next = SAFE;
          w_cnt_next   = LP_DEAD;
        end
      endcase
    end
  end

  assign bus.BUCK_Gate     = r_buck;
  assign bus.Full_Bridge_A = r_fb_a;
  assign bus.Full_Bridge_B = r_fb_b;

`ifdef PULSE_DROP_COUNT_EN
  logic [7:0] r_drop;

  always_ff @(posedge CLK_100MHz) begin
    if (reset)
      r_drop <= 8'd0;
    else if (w_swallow && (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end

  assign bus.pulsos_descartados = r_drop;
`else
  logic w_unused_swallow;
  assign w_unused_swallow       = w_swallow;
  assign bus.pulsos_descartados = 8'd0;
`endif

endmodule

// File: tb/tb_generador_tiempo_muerto.sv
// Scenario bench for generador_tiempo_muerto: expected gate triples {BUCK,A,B} are queued
// three cycles ahead as the PWM is driven and checked when their cycle arrives.
module tb_generador_tiempo_muerto;

`ifdef PULSE_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct {
    int         due;
    logic [2:0] g;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [2:0] obs_g;
  sb_t        sb_q[$];
  int         cyc;
  int         rel_cyc;
  int         exp_drops;
  int         n_cmp;
  int         n_err;

  generador_tiempo_muerto_if bus_if ();

  generador_tiempo_muerto #(.DEAD_CYCLES(50)) dut (
    .CLK_100MHz(clk),
    .reset     (rst),
    .bus       (bus_if)
  );

  assign obs_g = {bus_if.BUCK_Gate, bus_if.Full_Bridge_A, bus_if.Full_Bridge_B};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [7:0] exp_count();
    if (!DROP_EN)
      return 8'd0;
    return (exp_drops > 255) ? 8'd255 : 8'(exp_drops);
  endfunction

  task automatic test_reset();
    sb_t e;
    rst = 1'b1;
    bus_if.In_signal_conmutacion = 1'b0;
    bus_if.select_salida = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs_g !== 3'b000) begin
        n_err++;
        $display("FAIL reset_gates cyc=%0d got=%b expected=000", cyc, obs_g);
      end
      n_cmp++;
      if (bus_if.pulsos_descartados !== 8'd0) begin
        n_err++;
        $display("FAIL reset_count cyc=%0d got=%0d expected=0", cyc, bus_if.pulsos_descartados);
      end
    end
    rst = 1'b0;
    rel_cyc = cyc;
    exp_drops = 0;
    for (int d = 1; d <= 3; d++) begin
      e.due = cyc + d;
      e.g = 3'b000;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_buck();
    sb_t  e;
    logic v;
    for (int i = 0; i < 160; i++) begin
      tick();
      while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_g !== e.g) begin
          n_err++;
          $display("FAIL buck cyc=%0d got=%b expected=%b", cyc, obs_g, e.g);
        end
      end
      v = (((cyc / 20) % 2) == 1) || (i >= 150);
      bus_if.In_signal_conmutacion = v;
      e.due = cyc + 3;
      e.g = {((cyc + 3) >= (rel_cyc + 50)) && v, 2'b00};
      sb_q.push_back(e);
    end
  endtask

  task automatic test_sel_toggle();
    sb_t e;
    int  t1;
    int  t2;
    int  t3;
    int  d;
    t1 = cyc + 10;
    t2 = t1 + 20;
    t3 = t2 + 60;
    while (cyc < t3 + 60) begin
      tick();
      while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_g !== e.g) begin
          n_err++;
          $display("FAIL sel_toggle cyc=%0d got=%b expected=%b", cyc, obs_g, e.g);
        end
      end
      bus_if.In_signal_conmutacion = 1'b1;
      bus_if.select_salida = ((cyc >= t1) && (cyc < t2)) || (cyc >= t3);
      d = cyc + 3;
      e.due = d;
      e.g = (d <= t1)      ? 3'b100 :
            (d <= t2 + 50) ? 3'b000 :
            (d <= t3)      ? 3'b100 :
            (d <= t3 + 50) ? 3'b000 : 3'b010;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_fb_edges();
    sb_t e;
    int  m;
    int  k;
    int  d;
    m = cyc + 5;
    k = m + 80;
    while (cyc < k + 70) begin
      tick();
      while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_g !== e.g) begin
          n_err++;
          $display("FAIL fb_edges cyc=%0d got=%b expected=%b", cyc, obs_g, e.g);
        end
      end
      n_cmp++;
      if (bus_if.Full_Bridge_A && bus_if.Full_Bridge_B) begin
        n_err++;
        $display("FAIL fb_overlap cyc=%0d got A=1 B=1 expected not both", cyc);
      end
      bus_if.In_signal_conmutacion = !((cyc >= m) && (cyc < k));
      d = cyc + 3;
      e.due = d;
      e.g = (d <= m + 2)  ? 3'b010 :
            (d <= m + 52) ? 3'b000 :
            (d <= k + 2)  ? 3'b001 :
            (d <= k + 52) ? 3'b000 : 3'b010;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_swallow();
    sb_t e;
    int  f;
    int  p;
    int  d;
    f = cyc + 5;
    p = f + 70;
    while (cyc < p + 70) begin
      tick();
      while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_g !== e.g) begin
          n_err++;
          $display("FAIL swallow cyc=%0d got=%b expected=%b", cyc, obs_g, e.g);
        end
      end
      if (cyc == p + 53)
        exp_drops++;
      if (cyc == p + 52 || cyc == p + 53 || cyc == p + 69) begin
        n_cmp++;
        if (bus_if.pulsos_descartados !== exp_count()) begin
          n_err++;
          $display("FAIL swallow_count cyc=%0d got=%0d expected=%0d", cyc,
                   bus_if.pulsos_descartados, exp_count());
        end
      end
      bus_if.In_signal_conmutacion = (cyc < f) || ((cyc >= p) && (cyc < p + 20));
      d = cyc + 3;
      e.due = d;
      e.g = (d <= f + 2)  ? 3'b010 :
            (d <= f + 52) ? 3'b000 :
            (d <= p + 2)  ? 3'b001 :
            (d <= p + 52) ? 3'b000 : 3'b001;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_saturation();
    sb_t e;
    int  base;
    int  r;
    int  rd;
    base = cyc + 5;
    while (cyc < base + 18010) begin
      tick();
      while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_g !== e.g) begin
          n_err++;
          $display("FAIL saturation_gates cyc=%0d got=%b expected=%b", cyc, obs_g, e.g);
        end
      end
      r = cyc - base;
      if (r >= 0 && r < 18000 && (r % 60) == 59) begin
        exp_drops++;
        n_cmp++;
        if (bus_if.pulsos_descartados !== exp_count()) begin
          n_err++;
          $display("FAIL saturation_count cyc=%0d got=%0d expected=%0d", cyc,
                   bus_if.pulsos_descartados, exp_count());
        end
      end
      bus_if.In_signal_conmutacion = (r >= 0) && (r < 18000) && ((r % 60) < 5);
      rd = cyc + 3 - base;
      e.due = cyc + 3;
      e.g = (rd >= 0 && rd < 18000 && (rd % 60) >= 3 && (rd % 60) <= 52) ? 3'b000 : 3'b001;
      sb_q.push_back(e);
    end
  endtask

  task automatic test_reset_mid();
    sb_t e;
    int  i0;
    int  q;
    int  d;
    i0 = cyc + 5;
    q = i0 + 60;
    while (cyc < q + 70) begin
      tick();
      while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_g !== e.g) begin
          n_err++;
          $display("FAIL reset_mid cyc=%0d got=%b expected=%b", cyc, obs_g, e.g);
        end
      end
      if (cyc == q + 1 || cyc == q + 69) begin
        n_cmp++;
        if (bus_if.pulsos_descartados !== 8'd0) begin
          n_err++;
          $display("FAIL reset_mid_count cyc=%0d got=%0d expected=0", cyc,
                   bus_if.pulsos_descartados);
        end
      end
      rst = (cyc == q);
      if (cyc == q)
        exp_drops = 0;
      bus_if.In_signal_conmutacion = (cyc >= i0);
      d = cyc + 3;
      e.due = d;
      e.g = (d <= i0 + 2)  ? 3'b001 :
            (d <= i0 + 52) ? 3'b000 :
            (d <= q)       ? 3'b010 :
            (d <= q + 50)  ? 3'b000 : 3'b010;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    cyc = 0;
    rel_cyc = 0;
    exp_drops = 0;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_buck();
    test_sel_toggle();
    test_fb_edges();
    test_swallow();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/generador_tiempo_muerto.md
GENERADOR_TIEMPO_MUERTO -- requirements
Module: generador_tiempo_muerto

Interface
REQ-001 The block SHALL have one parameter: DEAD_CYCLES, default 50, dead-time length in CLK_100MHz periods; legal range 1..255.
REQ-002 CLK_100MHz  input  1  system clock, 100 MHz; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 In_signal_conmutacion  input  1  PWM from the duty-cycle stage; asynchronous to CLK_100MHz.
REQ-005 select_salida  input  1  output mode: 0 = BUCK, 1 = full bridge; already synchronized.
REQ-006 BUCK_Gate  output  1  buck switch gate, registered.
REQ-007 Full_Bridge_A  output  1  full-bridge diagonal A gate, registered.
REQ-008 Full_Bridge_B  output  1  full-bridge diagonal B gate (complement of A), registered.
REQ-009 pulsos_descartados  output  8  saturating count of PWM pulses swallowed by dead time (see Configuration).

Function
REQ-010 In_signal_conmutacion SHALL pass through a 2-flop synchronizer; s denotes the second-flop output.
REQ-011 The FSM SHALL have these states: SAFE, BUCK, FB_A, DT_AB, FB_B, DT_BA.
REQ-012 All three gate outputs SHALL be registered decodes of the next state; input-edge-to-output latency SHALL be exactly 3 clocks (2 sync + 1 register).
REQ-013 SAFE state behaviour:
- All gates 0.
- A DEAD_CYCLES down-counter is loaded on entry.
- On expiry: select_salida=0 -> BUCK; select_salida=1 -> FB_B if s=0, FB_A if s=1.
REQ-014 BUCK state: BUCK_Gate SHALL equal s (3-clock latency); Full_Bridge_A/B SHALL be 0.
REQ-015 FB_A state: Full_Bridge_A=1, B=0. When s=0, go to DT_AB and load the counter.
REQ-016 FB_B state: Full_Bridge_B=1, A=0. When s=1, go to DT_BA and load the counter.
REQ-017 DT_AB / DT_BA states: A=B=0 for exactly DEAD_CYCLES clocks. On expiry, go to FB_A if s=1, else FB_B.
REQ-018 A pulse that starts and ends inside one dead interval SHALL be swallowed: the state returns to the leg that was on before, and the swallow event is counted.
REQ-019 Full_Bridge_A and Full_Bridge_B SHALL never be 1 in the same cycle; every A/B handover SHALL include at least DEAD_CYCLES cycles with both low.
REQ-020 Any change of select_salida, from any state, SHALL force SAFE next cycle (all gates 0), then re-enter per REQ-013.
REQ-021 A select_salida change during SAFE SHALL restart the SAFE counter.
REQ-022 BUCK_Gate SHALL be 0 in every state except BUCK.

Reset
REQ-023 reset=1 SHALL within one clock set:
- state=SAFE, counter=DEAD_CYCLES;
- all gates 0, sync flops 0, pulsos_descartados=0.
REQ-024 After reset release, gates SHALL stay 0 for DEAD_CYCLES clocks before any turn-on; reset asserted mid-dead-time or mid-pulse SHALL also drive gates 0 next cycle.

Configuration
REQ-025 Macro PULSE_DROP_COUNT_EN:
- Defined: pulsos_descartados increments by 1 per REQ-018 event and saturates at 255.
- Undefined: the counter logic is omitted, pulsos_descartados is tied to 0, and all other behaviour is identical.

Verification
REQ-026 reset released, select_salida=0, DEAD_CYCLES=50, 1 kHz 50% PWM in -> BUCK_Gate 0 for first 50 clocks, then follows input with 3-clock delay; A=B=0 throughout.
REQ-027 select_salida=1, input rises at cycle k -> B falls at k+3, A rises at k+53; input falls at m -> A falls at m+3, B rises at m+53; A&B never both 1.
REQ-028 Full-bridge mode, 20-clock high pulse (< DEAD_CYCLES=50) -> A never rises, B low for 50 clocks then returns high; pulsos_descartados +1 if PULSE_DROP_COUNT_EN, else stays 0.
REQ-029 select_salida toggled 0->1 while BUCK_Gate=1 -> all gates 0 next cycle for 50 clocks, then FB_A/FB_B per s; toggle again mid-SAFE -> SAFE window restarts at 50.
REQ-030 reset pulsed for 1 clock while A=1 -> all gates 0 next cycle, pulsos_descartados=0, 50-clock SAFE before resumption.
REQ-031 With PULSE_DROP_COUNT_EN, 300 swallowed pulses -> pulsos_descartados=255 and holds.
